// File: rtl/montgomery_pkg.sv
`default_nettype none
// ============================================================================
// Module      : montgomery_pkg
// Description : Shared types and helpers for the radix-2 Montgomery engine.
//               state_t  - controller states
//               mode_t   - MUL (a*b*2^-k mod n) or RED (t*2^-k mod n)
//               clamp_k  - maps k=0 or k>width onto the full width
// Revision    : 1.0 - initial release
// ============================================================================
package montgomery_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_RED = 1'b1
  } mode_t;

  // A zero exponent or one wider than the datapath is meaningless for this
  // engine; both fall back to a full-width reduction.
  function automatic int clamp_k(input int k, input int dw);
    return ((k == 0) || (k > dw)) ? dw : k;
  endfunction

endpackage
`default_nettype wire

// File: rtl/montgomery_step.sv
`default_nettype none
// ============================================================================
// Module      : montgomery_step
// Description : One combinational radix-2 Montgomery iteration.
//               MUL: acc += a_bit*b; if odd acc += n; acc >>= 1
//               RED:                 if odd acc += n; acc >>= 1
// Ports       : i_acc   [2W+1] current accumulator
//               i_b     [W]    multiplier
//               i_n     [W]    odd modulus
//               i_a_bit [1]    current multiplicand bit
//               i_mode  [1]    MODE_MUL / MODE_RED
//               o_acc   [2W+1] accumulator after the iteration
// Revision    : 1.0 - initial release
// ============================================================================
module montgomery_step
  import montgomery_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [2*DATA_WIDTH:0]   i_acc,
  input  logic [DATA_WIDTH-1:0]   i_b,
  input  logic [DATA_WIDTH-1:0]   i_n,
  input  logic                    i_a_bit,
  input  mode_t                   i_mode,
  output logic [2*DATA_WIDTH:0]   o_acc
);

  localparam int ACC_W = 2*DATA_WIDTH + 1;
  // One spare bit so the two additions can never wrap before the halving.
  localparam int SUM_W = ACC_W + 1;

  logic [SUM_W-1:0] w_sum1;
  logic [SUM_W-1:0] w_sum2;

  assign w_sum1 = {1'b0, i_acc} +
                  (((i_mode == MODE_MUL) && i_a_bit) ? SUM_W'(i_b) : '0);
  // Adding odd n to an odd sum makes it even, so the shift below is exact.
  assign w_sum2 = w_sum1 + (w_sum1[0] ? SUM_W'(i_n) : '0);
  assign o_acc  = ACC_W'(w_sum2 >> 1);

endmodule
`default_nettype wire

// File: rtl/montgomery_mult_seq.sv
`default_nettype none
// ============================================================================
// Module      : montgomery_mult_seq
// Description : Sequential radix-2 Montgomery engine, one iteration per clock,
//               valid/ready handshake on input and output.
// Ports       : clk, reset (async, active-high)
//               in_valid/in_ready   operand handshake
//               mode                0 = MUL, 1 = RED
//               a, b [W]            MUL operands
//               t [2W]              RED operand
//               modulus [W]         odd n
//               bit_length [KW]     k, R = 2^k (clamped to W when 0 or >W)
//               out_valid/out_ready result handshake
//               out [W]             result
// Revision    : 1.0 - initial release
// ============================================================================
module montgomery_mult_seq
  import montgomery_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int KW         = $clog2(DATA_WIDTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      mode,
  input  logic [DATA_WIDTH-1:0]     a,
  input  logic [DATA_WIDTH-1:0]     b,
  input  logic [2*DATA_WIDTH-1:0]   t,
  input  logic [DATA_WIDTH-1:0]     modulus,
  input  logic [KW-1:0]             bit_length,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out
);

  localparam int ACC_W = 2*DATA_WIDTH + 1;

  state_t                r_state;
  state_t                w_state_nxt;
  mode_t                 r_mode;
  logic [ACC_W-1:0]      r_acc;
  logic [ACC_W-1:0]      w_acc_step;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_n;
  logic [DATA_WIDTH-1:0] r_out;
  logic [KW-1:0]         r_k;
  logic [KW-1:0]         r_i;
  logic [KW-1:0]         w_k;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_ge;
  logic [DATA_WIDTH-1:0] w_final;

  assign w_k      = KW'(clamp_k(int'(bit_length), DATA_WIDTH));
  assign w_accept = in_valid && (r_state == IDLE);
  assign w_last   = (r_i == (r_k - KW'(1)));

  // Final correction compares and subtracts at full accumulator width so a
  // large RED accumulator is never misjudged by its truncated low half.
  assign w_ge     = (r_acc >= ACC_W'(r_n));
  assign w_final  = w_ge ? DATA_WIDTH'(r_acc - ACC_W'(r_n))
                         : DATA_WIDTH'(r_acc);

  // The multiplicand is shifted right each step, so bit 0 is always a[i].
  montgomery_step #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_step (
    .i_acc   (r_acc),
    .i_b     (r_b),
    .i_n     (r_n),
    .i_a_bit (r_a[0]),
    .i_mode  (r_mode),
    .o_acc   (w_acc_step)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_last) w_state_nxt = FINAL;
      end
      FINAL: begin
        w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode <= MODE_MUL;
      r_acc  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_n    <= '0;
      r_k    <= '0;
      r_i    <= '0;
      r_out  <= '0;
    end else begin
      if (w_accept) begin
        r_mode <= mode_t'(mode);
        r_a    <= a;
        r_b    <= b;
        r_n    <= modulus;
        r_k    <= w_k;
        r_i    <= '0;
        r_acc  <= mode ? {1'b0, t} : '0;
      end else if (r_state == RUN) begin
        r_acc  <= w_acc_step;
        r_a    <= r_a >> 1;
        r_i    <= r_i + KW'(1);
      end else if (r_state == FINAL) begin
        r_out  <= w_final;
      end
    end
  end

  assign out = r_out;

endmodule
`default_nettype wire

// File: tb/tb_montgomery_mult_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_montgomery_mult_seq
// Description : Directed self-checking bench for montgomery_mult_seq,
//               DATA_WIDTH = 8, n = 13.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_montgomery_mult_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        mode;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] t;
  logic [7:0]  modulus;
  logic [3:0]  bit_length;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out;

  int n_cmp = 0;
  int n_bad = 0;

  montgomery_mult_seq #(
    .DATA_WIDTH (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mode       (mode),
    .a          (a),
    .b          (b),
    .t          (t),
    .modulus    (modulus),
    .bit_length (bit_length),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Accept at edge E0, wait for out_valid, optionally stall the consumer,
  // then handshake and confirm the return to IDLE.
  task automatic run_op(input string tag, input logic m, input logic [7:0] ia,
                        input logic [7:0] ib, input logic [15:0] it,
                        input logic [3:0] k, input logic [7:0] exp_out,
                        input int exp_lat, input int hold, input bit early);
    int lat;
    @(negedge clk);
    mode = m; a = ia; b = ib; t = it; modulus = 8'd13; bit_length = k;
    in_valid = 1'b1; out_ready = early;
    check_eq({tag, "_ready_idle"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    // Scramble inputs after acceptance; the engine must ignore them.
    in_valid = 1'b0; a = 8'hFF; b = 8'hFF; t = 16'hFFFF; modulus = 8'd0;
    bit_length = 4'd1; mode = ~m;
    check_eq({tag, "_ready_busy"}, 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_out"}, 32'(out), 32'(exp_out));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check_eq({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check_eq({tag, "_hold_out"}, 32'(out), 32'(exp_out));
      check_eq({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq({tag, "_valid_cleared"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_back_idle"}, 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; mode = 1'b0; a = '0; b = '0; t = '0;
    modulus = 8'd13; bit_length = 4'd4; out_ready = 1'b0;
    #12;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out", 32'(out), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // 7*5*16^-1 mod 13 = 3; 100*16^-1 mod 13 = 3; 13 reduces to exactly n -> 0;
    // k=0 clamps to 8: 35*256^-1 mod 13 = 1.
    run_op("mul_7x5",   1'b0, 8'd7, 8'd5, 16'd0,   4'd4, 8'd3, 5, 0, 1'b0);
    run_op("red_100",   1'b1, 8'd0, 8'd0, 16'd100, 4'd4, 8'd3, 5, 0, 1'b1);
    run_op("red_eq_n",  1'b1, 8'd0, 8'd0, 16'd13,  4'd4, 8'd0, 5, 0, 1'b0);
    run_op("mul_k0",    1'b0, 8'd7, 8'd5, 16'd0,   4'd0, 8'd1, 9, 0, 1'b0);
    run_op("mul_bp",    1'b0, 8'd7, 8'd5, 16'd0,   4'd4, 8'd3, 5, 10, 1'b0);

    // Abort mid-RUN: out still holds 3 from the previous op, so out=0 shows
    // the asynchronous clear.
    @(negedge clk);
    mode = 1'b0; a = 8'd7; b = 8'd5; bit_length = 4'd4; modulus = 8'd13;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    check_eq("pre_abort_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    #1;
    check_eq("abort_out_valid", 32'(out_valid), 32'd0);
    check_eq("abort_out", 32'(out), 32'd0);
    check_eq("abort_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    run_op("mul_after_rst", 1'b0, 8'd7, 8'd5, 16'd0, 4'd4, 8'd3, 5, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
